// File: rtl/read_write_arbiter_pkg.sv
// read_write_pkg
// Shared definitions for the read/write arbiter slice: default sizing,
// the lock FSM state type and the write-operand mux helper.
// The lock FSM is only built when ATOM_ARB_LOCK_EN is defined.
package read_write_pkg;

    localparam int DEF_COUNT_WIDTH = 3;
    localparam int DEF_NUM_REQ     = 4;

    // state   | meaning
    // IDLE    | plain round-robin, every valid requester is eligible
    // LOCKED  | only the owner may transfer, pointer frozen while held
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Operands are carried at 32 bits so one function serves any
    // COUNT_WIDTH up to 32; callers truncate the result.
    function automatic logic [31:0] mux_2(input logic        sel,
                                          input logic [31:0] a1,
                                          input logic [31:0] a0);
        return sel ? a1 : a0;
    endfunction

endpackage

// File: rtl/read_write_arbiter_if.sv
// read_write_arbiter_if
// Request/response bundle between requesters and the arbiter.
//   i__constant   : shared constant write operand
//   i__req_valid  : per-requester valid
//   i__req_pkt_1  : per-requester packet field, packed COUNT_WIDTH slices
//   i__req_sel    : per-requester operand select (0 constant, 1 packet)
//   i__req_lock   : per-requester lock request
//   o__req_ready  : grant, one-hot or zero
//   o__rsp_valid  : response strobe, one cycle after a transfer
//   o__rsp_id     : index of the answered requester
//   o__rsp_old    : register value before the answered write
//   o__write__pff : current shared register value
// master = requester side, slave = arbiter side.
interface read_write_arbiter_if #(
    parameter int COUNT_WIDTH = 3,
    parameter int NUM_REQ     = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [COUNT_WIDTH-1:0]         i__constant;
    logic [NUM_REQ-1:0]             i__req_valid;
    logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt_1;
    logic [NUM_REQ-1:0]             i__req_sel;
    logic [NUM_REQ-1:0]             i__req_lock;
    logic [NUM_REQ-1:0]             o__req_ready;
    logic                           o__rsp_valid;
    logic [ID_W-1:0]                o__rsp_id;
    logic [COUNT_WIDTH-1:0]         o__rsp_old;
    logic [COUNT_WIDTH-1:0]         o__write__pff;

    modport master (
        output i__constant, i__req_valid, i__req_pkt_1, i__req_sel, i__req_lock,
        input  o__req_ready, o__rsp_valid, o__rsp_id, o__rsp_old, o__write__pff
    );

    modport slave (
        input  i__constant, i__req_valid, i__req_pkt_1, i__req_sel, i__req_lock,
        output o__req_ready, o__rsp_valid, o__rsp_id, o__rsp_old, o__write__pff
    );

endinterface

// File: rtl/read_write_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin picker. Searches valid_i starting at ptr_i,
// wrapping modulo NUM_REQ; the first set bit found is granted.
//   valid_i : request mask (already qualified by the parent)
//   ptr_i   : search start index
//   grant_o : one-hot grant, zero when no request
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_write_arbiter.sv
// read_write_arbiter
// Shared COUNT_WIDTH register written by NUM_REQ requesters under
// round-robin arbitration. Each accepted write returns, one cycle later,
// the requester index and the value the register held before the write.
// Optional feature macro: ATOM_ARB_LOCK_EN -- a requester may lock the
// arbiter so only it is granted until it transfers with lock released.
// Ports: clk, rst (async, active-high), bus (read_write_arbiter_if.slave).
//
// state   | meaning
// IDLE    | round-robin over all valid requesters
// LOCKED  | only owner_q eligible; pointer held while lock stays asserted
module read_write_arbiter
    import read_write_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ
) (
    input  logic                  clk,
    input  logic                  rst,
    read_write_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [COUNT_WIDTH-1:0] reg_q, reg_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic [COUNT_WIDTH-1:0] rsp_old_q, rsp_old_d;

    logic [NUM_REQ-1:0]     elig_mask;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_id;
    logic                   xfer;
    logic                   hold_ptr;
    logic [COUNT_WIDTH-1:0] wr_val;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i (bus.i__req_valid & elig_mask),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    assign xfer   = |grant;
    assign wr_val = COUNT_WIDTH'(mux_2(bus.i__req_sel[grant_id],
                        32'(bus.i__req_pkt_1[int'(grant_id)*COUNT_WIDTH +: COUNT_WIDTH]),
                        32'(bus.i__constant)));

`ifdef ATOM_ARB_LOCK_EN
    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;

    // Eligibility depends only on registered state, so the grant path
    // has no combinational loop back through xfer.
    assign elig_mask = (state_q == LOCKED) ? (NUM_REQ'(1) << owner_q) : '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        hold_ptr = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && bus.i__req_lock[grant_id]) begin
                    state_d = LOCKED;
                    owner_d = grant_id;
                end
            end
            LOCKED: begin
                // Only the owner can be granted here, so grant_id == owner_q.
                if (xfer) begin
                    if (bus.i__req_lock[owner_q]) hold_ptr = 1'b1;
                    else                          state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic unused_lock;

    assign elig_mask   = '1;
    assign hold_ptr    = 1'b0;
    assign unused_lock = ^bus.i__req_lock;
`endif

    always_comb begin
        reg_d       = reg_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_old_d   = rsp_old_q;
        if (xfer) begin
            reg_d       = wr_val;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id;
            rsp_old_d   = reg_q;
            if (!hold_ptr) begin
                ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_old_q   <= '0;
        end else begin
            reg_q       <= reg_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_old_q   <= rsp_old_d;
        end
    end

    // Ready is forced low during reset so no requester sees a grant
    // that the held-in-reset flops would never act on.
    assign bus.o__req_ready  = rst ? '0 : grant;
    assign bus.o__rsp_valid  = rsp_valid_q;
    assign bus.o__rsp_id     = rsp_id_q;
    assign bus.o__rsp_old    = rsp_old_q;
    assign bus.o__write__pff = reg_q;

endmodule
